// File: rtl/regfile_access_arbiter_if.sv
// Requester, response and register-file port bundle for the
// register-file access arbiter.
interface regfile_access_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_rs1;
    logic [NREQ*AW-1:0] req_rs2;
    logic [NREQ*AW-1:0] req_rd;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data1;
    logic [DW-1:0]      rsp_data2;
    logic [AW-1:0]      rf_rs1;
    logic [AW-1:0]      rf_rs2;
    logic [AW-1:0]      rf_rd;
    logic [DW-1:0]      rf_writedata;
    logic               rf_regwrite;
    logic [DW-1:0]      rf_readdata1;
    logic [DW-1:0]      rf_readdata2;
    logic               busy;

    modport slave (
        input  req_valid, req_we, req_rs1, req_rs2,
        input  req_rd, req_wdata,
        input  rf_readdata1, rf_readdata2,
        output req_ready, rsp_valid, rsp_data1, rsp_data2,
        output rf_rs1, rf_rs2, rf_rd, rf_writedata,
        output rf_regwrite, busy
    );

    modport master (
        output req_valid, req_we, req_rs1, req_rs2,
        output req_rd, req_wdata,
        output rf_readdata1, rf_readdata2,
        input  req_ready, rsp_valid, rsp_data1, rsp_data2,
        input  rf_rs1, rf_rs2, rf_rd, rf_writedata,
        input  rf_regwrite, busy
    );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing one 2R/1W register file among NREQ
// requesters; x0 reads as zero and is never written.
module regfile_access_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_access_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CAPT  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic            we_q, we_d;
    logic [AW-1:0]   rs1_q, rs1_d;
    logic [AW-1:0]   rs2_q, rs2_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   d1_q, d1_d;
    logic [DW-1:0]   d2_q, d2_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_found;
    logic            wr_en;

    assign wr_en = we_q && (rd_q != '0);

    // Write-first bypass so a request reading its own rd sees the new value.
    function automatic logic [DW-1:0] operand(
        input logic [AW-1:0] rs,
        input logic [DW-1:0] rfd,
        input logic          wr,
        input logic [AW-1:0] rd,
        input logic [DW-1:0] wd
    );
        if (rs == '0)
            return '0;
        if (wr && rs == rd)
            return wd;
        return rfd;
    endfunction

    always_comb begin
        int j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ)
                j = j - NREQ;
            if (!gnt_found && bus.req_valid[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(j);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        we_d        = we_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        rsp_valid_d = '0;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    win_d   = gnt_idx;
                    we_d    = bus.req_we[gnt_idx];
                    rs1_d   = bus.req_rs1[int'(gnt_idx)*AW +: AW];
                    rs2_d   = bus.req_rs2[int'(gnt_idx)*AW +: AW];
                    rd_d    = bus.req_rd[int'(gnt_idx)*AW +: AW];
                    wdata_d = bus.req_wdata[int'(gnt_idx)*DW +: DW];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_CAPT;
            S_CAPT: begin
                d1_d = operand(rs1_q, bus.rf_readdata1,
                               wr_en, rd_q, wdata_q);
                d2_d = operand(rs2_q, bus.rf_readdata2,
                               wr_en, rd_q, wdata_q);
                rsp_valid_d = NREQ'(1) << win_q;
                ptr_d = (win_q == IW'(NREQ - 1)) ? '0
                                                 : win_q + IW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            we_q        <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            wdata_q     <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            we_q        <= we_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // rst_n gating keeps the combinational pulses low while reset is held.
    assign bus.req_ready = (rst_n && state_q == S_IDLE && gnt_found)
                         ? (NREQ'(1) << gnt_idx) : '0;
    assign bus.rf_regwrite  = rst_n && (state_q == S_ISSUE) && wr_en;
    assign bus.rf_rs1       = rs1_q;
    assign bus.rf_rs2       = rs2_q;
    assign bus.rf_rd        = rd_q;
    assign bus.rf_writedata = wdata_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data1    = d1_q;
    assign bus.rsp_data2    = d2_q;
    assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter with a behavioural
// 32x32 register file (async read, sync write).
module tb_regfile_access_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_access_arbiter_if #(.NREQ(2), .AW(5), .DW(32)) bus ();

    regfile_access_arbiter #(.NREQ(2), .AW(5), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] rf [32];

    always @(posedge clk)
        if (bus.rf_regwrite)
            rf[bus.rf_rd] <= bus.rf_writedata;

    assign bus.rf_readdata1 = rf[bus.rf_rs1];
    assign bus.rf_readdata2 = rf[bus.rf_rs2];

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int r, input logic we,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] wd);
        bus.req_we[r]          = we;
        bus.req_rs1[r*5 +: 5]  = rs1;
        bus.req_rs2[r*5 +: 5]  = rs2;
        bus.req_rd[r*5 +: 5]   = rd;
        bus.req_wdata[r*32 +: 32] = wd;
    endtask

    task automatic txn(input string tag, input int r, input logic we,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] wd,
                       input logic exp_wr, input logic [31:0] exp_d1,
                       input logic [31:0] exp_d2);
        set_req(r, we, rs1, rs2, rd, wd);
        bus.req_valid    = '0;
        bus.req_valid[r] = 1'b1;
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << r));
        tick();
        bus.req_valid = '0;
        set_req(r, ~we, ~rs1, ~rs2, ~rd, ~wd);
        chk({tag, "_busy"}, 32'(bus.busy), 32'(1));
        chk({tag, "_wr_issue"}, 32'(bus.rf_regwrite), 32'(exp_wr));
        chk({tag, "_rf_rd"}, 32'(bus.rf_rd), 32'(rd));
        chk({tag, "_rf_wdata"}, bus.rf_writedata, wd);
        tick();
        chk({tag, "_wr_capt"}, 32'(bus.rf_regwrite), 32'(0));
        chk({tag, "_rsp_early"}, 32'(bus.rsp_valid), 32'(0));
        tick();
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(1 << r));
        chk({tag, "_d1"}, bus.rsp_data1, exp_d1);
        chk({tag, "_d2"}, bus.rsp_data2, exp_d2);
        chk({tag, "_idle"}, 32'(bus.busy), 32'(0));
        tick();
        chk({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            rf[i] = 32'h1000_0000 + 32'(i);
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_rd    = '0;
        bus.req_wdata = '0;

        #12;
        chk("rst_ready", 32'(bus.req_ready), 32'(0));
        chk("rst_rsp", 32'(bus.rsp_valid), 32'(0));
        chk("rst_wr", 32'(bus.rf_regwrite), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_rf_rd", 32'(bus.rf_rd), 32'(0));
        chk("rst_d1", bus.rsp_data1, 32'h0);
        rst_n = 1'b1;
        tick();

        txn("write", 0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF,
            1'b1, 32'h0, 32'h0);
        txn("readback", 1, 1'b0, 5'd5, 5'd0, 5'd1, 32'h0,
            1'b0, 32'hDEADBEEF, 32'h0);
        txn("x0", 0, 1'b1, 5'd0, 5'd3, 5'd0, 32'h12345678,
            1'b0, 32'h0, 32'h1000_0003);
        txn("bypass", 1, 1'b1, 5'd7, 5'd7, 5'd7, 32'hA5A5A5A5,
            1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5);

        set_req(0, 1'b0, 5'd5, 5'd7, 5'd0, 32'h0);
        set_req(1, 1'b0, 5'd7, 5'd5, 5'd0, 32'h0);
        bus.req_valid = 2'b11;
        #1;
        for (int t = 0; t < 6; t++) begin
            int n;
            n = 0;
            while (bus.req_ready == '0 && n < 8) begin
                tick();
                n++;
            end
            chk("fair_grant", 32'(bus.req_ready), 32'(1 << (t % 2)));
            tick();
            if (t == 5)
                bus.req_valid = '0;
            tick();
            tick();
            chk("fair_rsp", 32'(bus.rsp_valid), 32'(1 << (t % 2)));
        end
        tick();

        txn("pre_rst", 0, 1'b0, 5'd7, 5'd5, 5'd0, 32'h0,
            1'b0, 32'hA5A5A5A5, 32'hDEADBEEF);

        set_req(1, 1'b1, 5'd0, 5'd0, 5'd9, 32'h0000_0055);
        bus.req_valid = 2'b10;
        #1;
        chk("abort_ready", 32'(bus.req_ready), 32'(2));
        tick();
        bus.req_valid = '0;
        chk("abort_wr_issue", 32'(bus.rf_regwrite), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_wr_drop", 32'(bus.rf_regwrite), 32'(0));
        chk("abort_busy", 32'(bus.busy), 32'(0));
        tick();
        tick();
        chk("abort_rsp", 32'(bus.rsp_valid), 32'(0));
        rst_n = 1'b1;
        tick();
        chk("abort_rsp2", 32'(bus.rsp_valid), 32'(0));

        set_req(0, 1'b0, 5'd9, 5'd0, 5'd0, 32'h0);
        bus.req_valid = 2'b11;
        #1;
        chk("post_rst_grant", 32'(bus.req_ready), 32'(1));
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        chk("post_rst_rsp", 32'(bus.rsp_valid), 32'(1));
        chk("post_rst_d1", bus.rsp_data1, 32'h1000_0009);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
Shares the single 32x32 register file (two read ports, one write port) among NREQ requesters, e.g. the layer-sequencer core and the weight/activation loader. It accepts one request per transaction using round-robin arbitration and drives the register-file address, data and write-enable ports. It returns both read operands to the winning requester. Register 0 is hard-wired zero: writes to it are suppressed and reads of it return zero.

Parameters:
NREQ, 2, number of requesters (2..4)
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  request pending, one bit per requester
req_ready  out  NREQ  one-cycle accept pulse, one-hot
req_we  in  NREQ  request includes a write of rd
req_rs1  in  NREQ*AW  read address 1, requester i at bits [i*AW +: AW]
req_rs2  in  NREQ*AW  read address 2, same packing
req_rd  in  NREQ*AW  write address, same packing
req_wdata  in  NREQ*DW  write data, requester i at bits [i*DW +: DW]
rsp_valid  out  NREQ  one-cycle response pulse to the owning requester
rsp_data1  out  DW  operand for rs1, valid with rsp_valid
rsp_data2  out  DW  operand for rs2, valid with rsp_valid
rf_rs1  out  AW  register-file read address 1
rf_rs2  out  AW  register-file read address 2
rf_rd  out  AW  register-file write address
rf_writedata  out  DW  register-file write data
rf_regwrite  out  1  register-file write enable
rf_readdata1  in  DW  register-file read data 1
rf_readdata2  in  DW  register-file read data 2
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; round-robin pointer = 0.
  - All outputs = 0, including rf_regwrite, req_ready and rsp_valid.
- FSM states and transitions:
  - IDLE:
    - If any req_valid is set, select the winner: the first set bit found scanning from the pointer upward, wrapping modulo NREQ.
    - Pulse req_ready[winner] for this one cycle.
    - Latch the winner index, we, rs1, rs2, rd and wdata.
    - Go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE:
    - Drive rf_rs1, rf_rs2, rf_rd and rf_writedata from the latched fields.
    - rf_regwrite = latched we AND (rd != 0), asserted for exactly this cycle.
    - Go to CAPTURE.
  - CAPTURE:
    - rf_regwrite = 0; read addresses held.
    - Register rsp_data1/rsp_data2 and pulse rsp_valid[winner] in the cycle after CAPTURE.
    - Pointer = (winner + 1) mod NREQ.
    - Go to IDLE.
- Latency and throughput:
  - Accept to rsp_valid is 3 cycles.
  - One transaction per 3 cycles maximum; back-to-back accept is allowed in the cycle rsp_valid is high.
- Operand rules, applied per port:
  - If rs == 0, data = 0.
  - Else if latched we AND rd != 0 AND rs == rd, data = latched wdata (write-first bypass).
  - Else data = rf_readdata.
- Requester contract:
  - Requests are captured only on the accept cycle; later changes to request fields are ignored.
  - A requester holds req_valid until it sees req_ready.
  - Deasserting req_valid before req_ready is legal: that requester simply does not win.
- Fairness: when all requesters are continuously valid, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 transactions.
- Outputs outside an active transaction:
  - rf_* address and data outputs hold their last values.
  - rsp_data1/rsp_data2 hold their last values.
  - req_ready and rsp_valid are 0 except for their single-cycle pulses.
- Reset mid-transaction:
  - Aborts the transaction immediately.
  - No rsp_valid is issued and rf_regwrite drops asynchronously.
  - A write whose ISSUE cycle has completed is not rolled back.
- A request arriving while busy waits in IDLE arbitration; there is no queueing inside the block.

Test Plan:
- Reset then single write: requester 0 we=1, rd=5, wdata=0xDEADBEEF -> req_ready[0] pulses; rf_regwrite high exactly 1 cycle with rf_rd=5; rsp_valid[0] 3 cycles after accept.
- Read back: requester 1 we=0, rs1=5, rs2=0 after the write -> rsp_data1=0xDEADBEEF, rsp_data2=0, rsp_valid[1] only.
- x0 protection: we=1, rd=0, wdata=0x12345678, rs1=0 -> rf_regwrite stays 0; rsp_data1=0.
- Bypass: we=1, rd=7, wdata=0xA5A5A5A5, rs1=7, rs2=7 -> rsp_data1=rsp_data2=0xA5A5A5A5.
- Fairness: both requesters valid continuously for 6 transactions -> grant order 0,1,0,1,0,1; each req_ready one-hot.
- Mid-op reset: assert rst_n low during ISSUE -> rf_regwrite=0 and busy=0 immediately; no rsp_valid; next request after release is granted to requester 0.
